compare_sort_ctrl: RTL and testbench

//  Sequencer that sorts a small buffer of bytes using one shared 8-bit magnitude comparator.

---
 rtl/compare_sort_ctrl_pkg.sv | 22 ++
 rtl/compare_sort_ctrl_compare8_unit.sv | 19 +
 rtl/compare_sort_ctrl.sv | 138 +++++++++++++
 tb/tb_compare_sort_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/compare_sort_ctrl_pkg.sv
// Shared types and encodings for the byte-buffer sort sequencer and its comparator.
package cmp_sort_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

    // Equal operands never count as out of order, which keeps the sort stable.
    function automatic logic outOfOrder(input logic [2:0] code, input logic dir);
        return (dir == DIR_ASC) ? (code == CMP_GT) : (code == CMP_LT);
    endfunction

endpackage

// File: rtl/compare_sort_ctrl_compare8_unit.sv
// Combinational 8-bit magnitude comparator producing a one-hot {gt,eq,lt} code.
module compare8_unit
    import cmp_sort_pkg::*;
(
    input  logic [7:0] iA,
    input  logic [7:0] iB,
    output logic [2:0] oCode
);

    always_comb begin
        oCode = CMP_EQ;
        if (iA > iB) begin
            oCode = CMP_GT;
        end else if (iA < iB) begin
            oCode = CMP_LT;
        end
    end

endmodule

// File: rtl/compare_sort_ctrl.sv
// Serial-load byte buffer sorted in place by a bubble-sort FSM around one shared comparator.
module compare_sort_ctrl
    import cmp_sort_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iClear,
    input  logic         iLoad_valid,
    input  logic [W-1:0] iLoad_data,
    output logic         oLoad_ready,
    input  logic         iStart,
    input  logic         iDir,
    output logic         oBusy,
    output logic         oDone,
    input  logic [2:0]   iRd_idx,
    output logic [W-1:0] oRd_data,
    output logic [5:0]   oSwap_cnt
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(N + 1);

    logic [W-1:0]  bufMem [N];
    state_t        state;
    state_t        stateNext;
    logic [CW-1:0] count;
    logic [IW-1:0] j;
    logic [IW-1:0] jPlus;
    logic [IW-1:0] limit;
    logic          dir;
    logic          swapped;

    logic [W-1:0]  opA;
    logic [W-1:0]  opB;
    logic [2:0]    cmpCode;
    logic          loadReady;
    logic          loadFire;
    logic          startFire;
    logic          swapNow;
    logic          endPass;

    assign jPlus = j + IW'(1);
    assign opA   = bufMem[j];
    assign opB   = bufMem[jPlus];

    compare8_unit uCmp (
        .iA    (opA),
        .iB    (opB),
        .oCode (cmpCode)
    );

    assign oRd_data = (32'(iRd_idx) < N) ? bufMem[iRd_idx[IW-1:0]] : '0;

    always_comb begin
        stateNext = state;
        loadReady = (state == IDLE) && (count < CW'(N));
        // Clear outranks load, and either one suppresses a start in the same cycle.
        loadFire  = (state == IDLE) && !iClear && iLoad_valid && loadReady;
        startFire = (state == IDLE) && !iClear && !(iLoad_valid && loadReady) && iStart;
        swapNow   = (state == SORT) && outOfOrder(cmpCode, dir);
        endPass   = (j == limit - IW'(1));

        case (state)
            IDLE: begin
                if (startFire) begin
                    stateNext = (count < CW'(2)) ? DONE : SORT;
                end
            end
            SORT: begin
                if (endPass && (!(swapped || swapNow) || limit == IW'(1))) begin
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        oLoad_ready = loadReady;
        oBusy       = (state == SORT);
        oDone       = (state == DONE);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            count     <= '0;
            j         <= '0;
            limit     <= '0;
            dir       <= DIR_ASC;
            swapped   <= 1'b0;
            oSwap_cnt <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                bufMem[i] <= '0;
            end
        end else begin
            if (state == IDLE && iClear) begin
                count <= '0;
            end else if (loadFire) begin
                bufMem[IW'(count)] <= iLoad_data;
                count              <= count + CW'(1);
            end else if (startFire) begin
                dir       <= iDir;
                j         <= '0;
                limit     <= IW'(count - CW'(1));
                swapped   <= 1'b0;
                oSwap_cnt <= '0;
            end

            if (state == SORT) begin
                if (swapNow) begin
                    bufMem[j]     <= opB;
                    bufMem[jPlus] <= opA;
                    oSwap_cnt     <= oSwap_cnt + 6'd1;
                end
                // At a pass end that finishes the sort these updates are harmless.
                if (endPass) begin
                    j       <= '0;
                    limit   <= limit - IW'(1);
                    swapped <= 1'b0;
                end else begin
                    j       <= jPlus;
                    swapped <= swapped | swapNow;
                end
            end
        end
    end

endmodule

// File: tb/tb_compare_sort_ctrl.sv
// Self-checking bench: directed scenarios plus randomized loads/sorts against an abstract model.
module tb_compare_sort_ctrl;

    localparam int N = 4;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iClear;
    logic       iLoad_valid;
    logic [7:0] iLoad_data;
    logic       oLoad_ready;
    logic       iStart;
    logic       iDir;
    logic       oBusy;
    logic       oDone;
    logic [2:0] iRd_idx;
    logic [7:0] oRd_data;
    logic [5:0] oSwap_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] mBuf [N];
    int         mCount;

    compare_sort_ctrl #(.N(N), .W(8)) dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iClear      (iClear),
        .iLoad_valid (iLoad_valid),
        .iLoad_data  (iLoad_data),
        .oLoad_ready (oLoad_ready),
        .iStart      (iStart),
        .iDir        (iDir),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .iRd_idx     (iRd_idx),
        .oRd_data    (oRd_data),
        .oSwap_cnt   (oSwap_cnt)
    );

    always #10 iClk = ~iClk;

    task automatic tick;
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ooo(input logic [7:0] a, input logic [7:0] b, input logic d);
        return d ? (a < b) : (a > b);
    endfunction

    task automatic checkRead(input string tag);
        for (int i = 0; i < 8; i++) begin
            iRd_idx = 3'(i);
            #1;
            chk({tag, "_rd"}, 32'(oRd_data), (i < N) ? 32'(mBuf[i]) : 32'd0);
        end
    endtask

    task automatic modelReset;
        for (int i = 0; i < N; i++) mBuf[i] = 8'h00;
        mCount = 0;
    endtask

    task automatic doClear;
        iClear = 1'b1;
        tick();
        iClear = 1'b0;
        mCount = 0;
        chk("clear_ready", 32'(oLoad_ready), 32'd1);
    endtask

    task automatic loadByte(input logic [7:0] d);
        bit accepted;
        accepted    = (mCount < N);
        iLoad_valid = 1'b1;
        iLoad_data  = d;
        tick();
        iLoad_valid = 1'b0;
        if (accepted) begin
            mBuf[mCount] = d;
            mCount++;
        end
        chk("load_ready", 32'(oLoad_ready), 32'(mCount < N));
    endtask

    // Expected results come from inversion counting and a stable insertion sort,
    // not from stepping a bubble sort.
    task automatic runSort(input logic d, input string tag);
        int         cnt;
        int         inv;
        int         maxLeft;
        int         left;
        int         passes;
        int         expCyc;
        int         busyCyc;
        int         guard;
        int         pos;
        logic [7:0] sorted [$];
        cnt     = mCount;
        inv     = 0;
        maxLeft = 0;
        for (int b = 0; b < cnt; b++) begin
            left = 0;
            for (int a = 0; a < b; a++) if (ooo(mBuf[a], mBuf[b], d)) left++;
            inv += left;
            if (left > maxLeft) maxLeft = left;
        end
        passes = (cnt < 2) ? 0 : ((maxLeft + 1 < cnt - 1) ? maxLeft + 1 : cnt - 1);
        expCyc = 0;
        for (int p = 1; p <= passes; p++) expCyc += cnt - p;
        sorted = {};
        for (int k = 0; k < cnt; k++) begin
            pos = sorted.size();
            while (pos > 0 && ooo(sorted[pos-1], mBuf[k], d)) pos--;
            sorted.insert(pos, mBuf[k]);
        end

        iDir   = d;
        iStart = 1'b1;
        tick();
        iStart  = 1'b0;
        busyCyc = 0;
        guard   = 0;
        while (!oDone && guard < 64) begin
            if (oBusy) busyCyc++;
            iClear      = 1'($urandom);
            iLoad_valid = 1'($urandom);
            iLoad_data  = 8'($urandom);
            iStart      = 1'($urandom);
            iDir        = 1'($urandom);
            tick();
            guard++;
        end
        iClear      = 1'b0;
        iLoad_valid = 1'b0;
        iStart      = 1'b0;
        chk({tag, "_done"}, 32'(oDone), 32'd1);
        chk({tag, "_busy_in_done"}, 32'(oBusy), 32'd0);
        chk({tag, "_sort_cycles"}, 32'(busyCyc), 32'(expCyc));
        chk({tag, "_swaps"}, 32'(oSwap_cnt), 32'(inv));
        for (int k = 0; k < cnt; k++) mBuf[k] = sorted[k];
        checkRead(tag);
        tick();
        chk({tag, "_done_pulse"}, 32'(oDone), 32'd0);
        chk({tag, "_ready_after"}, 32'(oLoad_ready), 32'(mCount < N));
    endtask

    initial begin
        int n;
        iRst        = 1'b1;
        iClear      = 1'b0;
        iLoad_valid = 1'b0;
        iLoad_data  = 8'h00;
        iStart      = 1'b0;
        iDir        = 1'b0;
        iRd_idx     = 3'd0;
        modelReset();
        tick();
        tick();
        iRst = 1'b0;
        chk("rst_busy", 32'(oBusy), 32'd0);
        chk("rst_done", 32'(oDone), 32'd0);
        chk("rst_ready", 32'(oLoad_ready), 32'd1);
        chk("rst_swaps", 32'(oSwap_cnt), 32'd0);
        checkRead("rst");

        // Ascending sort with two swaps over three passes
        loadByte(8'hAA); loadByte(8'hAB); loadByte(8'hA9); loadByte(8'hBA);
        runSort(1'b0, "t1");
        chk("t1_swaps_const", 32'(oSwap_cnt), 32'd2);

        // Already ordered: single pass, no swaps
        doClear();
        loadByte(8'h10); loadByte(8'h20); loadByte(8'h30); loadByte(8'h40);
        runSort(1'b0, "t2");
        chk("t2_swaps_const", 32'(oSwap_cnt), 32'd0);

        // Descending with an equal pair, then an in-place re-sort ascending
        doClear();
        loadByte(8'h5A); loadByte(8'hAA); loadByte(8'hAA); loadByte(8'hBA);
        runSort(1'b1, "t3");
        runSort(1'b0, "t3_resort");

        // One-byte sort and overflow of the buffer
        doClear();
        loadByte(8'h3C);
        runSort(1'b0, "t4_single");
        doClear();
        for (int i = 0; i < 5; i++) loadByte(8'hC0 + 8'(i));
        checkRead("t4_overflow");

        // Reset in the middle of a sort
        doClear();
        loadByte(8'hAA); loadByte(8'hAB); loadByte(8'hA9); loadByte(8'hBA);
        iDir   = 1'b0;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        tick();
        tick();
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        modelReset();
        chk("t5_busy", 32'(oBusy), 32'd0);
        chk("t5_done", 32'(oDone), 32'd0);
        chk("t5_ready", 32'(oLoad_ready), 32'd1);
        checkRead("t5");
        tick();
        chk("t5_no_done", 32'(oDone), 32'd0);
        chk("t5_still_idle", 32'(oBusy), 32'd0);

        // Priority: load beats start, clear beats start
        iLoad_valid = 1'b1;
        iLoad_data  = 8'h77;
        iStart      = 1'b1;
        tick();
        iLoad_valid = 1'b0;
        iStart      = 1'b0;
        mBuf[mCount] = 8'h77;
        mCount++;
        chk("t6_load_busy", 32'(oBusy), 32'd0);
        chk("t6_load_done", 32'(oDone), 32'd0);
        checkRead("t6_load");
        loadByte(8'h11);
        iClear = 1'b1;
        iStart = 1'b1;
        tick();
        iClear = 1'b0;
        iStart = 1'b0;
        mCount = 0;
        chk("t6_clr_busy", 32'(oBusy), 32'd0);
        chk("t6_clr_done", 32'(oDone), 32'd0);
        chk("t6_clr_ready", 32'(oLoad_ready), 32'd1);
        runSort(1'b0, "t6_empty");

        // Randomized buffers, dup-rich half of the time
        for (int it = 0; it < 24; it++) begin
            doClear();
            n = $urandom_range(0, N + 1);
            for (int i = 0; i < n; i++) begin
                if (it % 2 == 0) loadByte(8'($urandom_range(0, 3)) << 6);
                else             loadByte(8'($urandom));
            end
            runSort(1'($urandom), "rnd");
            if ($urandom_range(0, 2) == 0) runSort(1'($urandom), "rnd_resort");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
